// File: rtl/rr_grant_pkg.sv
// Shared constants and types for the round-robin grant controller.
package rr_grant_pkg;

    localparam int N_REQ  = 8;
    localparam int CODE_W = 3;
    localparam int HOLD_W = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } rr_state_t;

endpackage

// File: rtl/rr_grant_ctrl_if.sv
// Request/grant bundle between the requesters (master) and the arbiter (slave).
interface rr_grant_ctrl_if;
    import rr_grant_pkg::*;

    logic [N_REQ-1:0]  req;
    logic              done;
    logic [N_REQ-1:0]  grant;
    logic [CODE_W-1:0] code;
    logic              valid;
    logic              timeout;

    modport master (
        output req, done,
        input  grant, code, valid, timeout
    );

    modport slave (
        input  req, done,
        output grant, code, valid, timeout
    );

endinterface

// File: rtl/rr_grant_enc8.sv
// 8-input one-hot encoder; an all-zero input encodes to 0.
module rr_grant_enc8
    import rr_grant_pkg::*;
(
    input  logic [N_REQ-1:0]  i_onehot,
    output logic [CODE_W-1:0] o_code
);

    // OR together the indices of the set bits; exact for one-hot inputs.
    always_comb begin
        o_code = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (i_onehot[i]) begin
                o_code = o_code | CODE_W'(i);
            end
        end
    end

endmodule

// File: rtl/rr_pick8.sv
// Combinational round-robin winner search: first set request starting at ptr,
// wrapping past the top index back to 0.
module rr_pick8
    import rr_grant_pkg::*;
(
    input  logic [N_REQ-1:0]  i_req,
    input  logic [CODE_W-1:0] i_ptr,
    output logic [N_REQ-1:0]  o_win,
    output logic              o_any
);

    logic [CODE_W-1:0] w_idx;
    logic              w_found;

    // Walk the requests in priority order from ptr and keep the first hit.
    always_comb begin
        o_win   = '0;
        w_found = 1'b0;
        w_idx   = i_ptr;
        for (int k = 0; k < N_REQ; k++) begin
            w_idx = i_ptr + CODE_W'(k);
            if (!w_found && i_req[w_idx]) begin
                o_win[w_idx] = 1'b1;
                w_found      = 1'b1;
            end
        end
    end

    assign o_any = |i_req;

endmodule

// File: rtl/rr_grant_ctrl.sv
// Round-robin arbiter in front of the one-hot encoder. Grants one requester at
// a time, holds until done or the request drops, then rotates priority.
// Optional feature macro: RR_GRANT_TIMEOUT_EN (hold counter with forced revoke
// after HOLD_MAX cycles in GRANT; without it timeout is tied to 0).
module rr_grant_ctrl
    import rr_grant_pkg::*;
#(
    parameter int HOLD_MAX = 16
)(
    input  logic           clk,
    input  logic           rst,
    rr_grant_ctrl_if.slave bus
);

    if (HOLD_MAX < 2 || HOLD_MAX > 255) begin : g_hold_chk
        $error("HOLD_MAX must be in 2..255");
    end

    rr_state_t         r_state;
    rr_state_t         w_state_nxt;
    logic [N_REQ-1:0]  r_grant;
    logic [N_REQ-1:0]  w_grant_nxt;
    logic [N_REQ-1:0]  w_win;
    logic [CODE_W-1:0] r_code;
    logic [CODE_W-1:0] w_code_nxt;
    logic [CODE_W-1:0] r_ptr;
    logic              r_valid;
    logic              r_timeout;
    logic              w_any;
    logic              w_release;
    logic              w_revoke;

    rr_pick8 u_pick (
        .i_req (bus.req),
        .i_ptr (r_ptr),
        .o_win (w_win),
        .o_any (w_any)
    );

    // The encoder sees the next-state grant so code is registered alongside grant.
    rr_grant_enc8 u_enc (
        .i_onehot (w_grant_nxt),
        .o_code   (w_code_nxt)
    );

    // The owner lets go explicitly, or its request line falls.
    assign w_release = bus.done || !bus.req[r_code];

`ifdef RR_GRANT_TIMEOUT_EN
    logic [HOLD_W-1:0] r_hold;
    logic              w_limit;

    assign w_limit  = (r_hold == HOLD_W'(HOLD_MAX - 1));
    // A release at the limit wins; only a silent owner is revoked.
    assign w_revoke = (r_state == GRANT) && w_limit && !w_release;

    // Count cycles spent in GRANT; IDLE keeps it at zero so entry starts from 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold <= '0;
        end else if (r_state == IDLE) begin
            r_hold <= '0;
        end else begin
            r_hold <= r_hold + HOLD_W'(1);
        end
    end
`else
    assign w_revoke = 1'b0;
`endif

    // Next state and next grant vector; no preemption while a grant is held.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        case (r_state)
            IDLE: begin
                w_grant_nxt = '0;
                if (w_any) begin
                    w_state_nxt = GRANT;
                    w_grant_nxt = w_win;
                end
            end
            GRANT: begin
                if (w_release || w_revoke) begin
                    w_state_nxt = IDLE;
                    w_grant_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_grant   <= '0;
            r_code    <= '0;
            r_valid   <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_grant   <= w_grant_nxt;
            r_code    <= w_code_nxt;
            r_valid   <= (w_state_nxt == GRANT);
            r_timeout <= w_revoke;
        end
    end

    // Rotate priority to just past the winner each time a grant is issued.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (r_state == IDLE && w_any) begin
            r_ptr <= w_code_nxt + CODE_W'(1);
        end
    end

    assign bus.grant   = r_grant;
    assign bus.code    = r_code;
    assign bus.valid   = r_valid;
    assign bus.timeout = r_timeout;

endmodule

// File: tb/tb_rr_grant_ctrl.sv
// Scoreboard bench for rr_grant_ctrl: directed scenarios plus random traffic,
// checked against a behavioural arbiter model.
module tb_rr_grant_ctrl;
    import rr_grant_pkg::*;

    localparam int HOLD_MAX = 4;
`ifdef RR_GRANT_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    typedef struct packed {
        logic [7:0] grant;
        logic [2:0] code;
        logic       valid;
        logic       timeout;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    rr_grant_ctrl_if bus ();

    rr_grant_ctrl #(.HOLD_MAX(HOLD_MAX)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb_q[$];

    // Reference model: who owns the resource, where priority starts, how long held.
    int owner = -1;
    int m_ptr = 0;
    int m_hold = 0;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Advance the model by one clock edge given the inputs, return the outputs.
    function automatic exp_t model_step(input logic [7:0] r, input logic d, input logic rs);
        exp_t e;
        bit   to;
        bit   rel;
        to = 1'b0;
        if (rs) begin
            owner = -1; m_ptr = 0; m_hold = 0;
        end else if (owner < 0) begin
            if (r != 8'h00) begin
                for (int k = 0; k < 8; k++) begin
                    if (owner < 0 && r[(m_ptr + k) % 8]) owner = (m_ptr + k) % 8;
                end
                m_ptr  = (owner + 1) % 8;
                m_hold = 0;
            end
        end else begin
            rel = d || !r[owner];
            if (!rel && TO_EN && m_hold == HOLD_MAX - 1) to = 1'b1;
            if (rel || to) owner = -1;
            else m_hold++;
        end
        e.grant   = (owner >= 0) ? (8'h01 << owner) : 8'h00;
        e.code    = (owner >= 0) ? 3'(owner) : 3'd0;
        e.valid   = (owner >= 0);
        e.timeout = to;
        return e;
    endfunction

    // Drive one cycle of inputs shortly after the falling edge and queue the
    // outputs expected after the following rising edge.
    task automatic cycle(input logic [7:0] r, input logic d, input logic rs);
        logic was_rst;
        @(negedge clk);
        #1;
        was_rst = rst;
        bus.req  = r;
        bus.done = d;
        rst      = rs;
        sb_q.push_back(model_step(r, d, rs));
        if (rs && !was_rst) begin
            #1;
            chk("async_rst_grant", bus.grant, 8'h00);
            chk("async_rst_code", {5'd0, bus.code}, 8'h00);
            chk("async_rst_valid", {7'd0, bus.valid}, 8'h00);
            chk("async_rst_timeout", {7'd0, bus.timeout}, 8'h00);
        end
    endtask

    // Monitor: compare DUT outputs with the oldest expectation each falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("grant", bus.grant, e.grant);
                chk("code", {5'd0, bus.code}, {5'd0, e.code});
                chk("valid", {7'd0, bus.valid}, {7'd0, e.valid});
                chk("timeout", {7'd0, bus.timeout}, {7'd0, e.timeout});
            end
        end
    end

    initial begin
        logic [7:0] r;
        bus.req  = 8'h00;
        bus.done = 1'b0;
        // Reset then quiet inputs.
        cycle(8'h00, 1'b0, 1'b1);
        cycle(8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) cycle(8'h00, 1'b0, 1'b0);
        // Requesters 0 and 7; done in IDLE ignored, pointer wraps after 7.
        cycle(8'h00, 1'b1, 1'b0);
        cycle(8'h81, 1'b0, 1'b0);
        cycle(8'h81, 1'b1, 1'b0);
        cycle(8'h81, 1'b0, 1'b0);
        cycle(8'h81, 1'b1, 1'b0);
        cycle(8'h81, 1'b0, 1'b0);
        cycle(8'h81, 1'b1, 1'b0);
        // All requesting, done pulsed each grant: codes rotate 0..7,0.
        cycle(8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 9; i++) begin
            cycle(8'hFF, 1'b0, 1'b0);
            cycle(8'hFF, 1'b1, 1'b0);
        end
        // Requester 3 drops its line without done.
        cycle(8'h08, 1'b0, 1'b0);
        cycle(8'h08, 1'b0, 1'b0);
        cycle(8'h00, 1'b0, 1'b0);
        // Requester 5, async reset mid-grant, then re-grant from ptr 0.
        cycle(8'h20, 1'b0, 1'b0);
        cycle(8'h20, 1'b0, 1'b0);
        cycle(8'h20, 1'b0, 1'b1);
        cycle(8'h20, 1'b0, 1'b0);
        cycle(8'h21, 1'b1, 1'b0);
        cycle(8'h21, 1'b0, 1'b0);
        cycle(8'h21, 1'b1, 1'b0);
        // Long hold with no release: revoked only in the timeout build.
        for (int i = 0; i < 10; i++) cycle(8'h04, 1'b0, 1'b0);
        // Release exactly at the limit counts as a normal release.
        cycle(8'h00, 1'b0, 1'b0);
        cycle(8'h00, 1'b0, 1'b0);
        cycle(8'h02, 1'b0, 1'b0);
        for (int i = 0; i < HOLD_MAX - 1; i++) cycle(8'h02, 1'b0, 1'b0);
        cycle(8'h02, 1'b1, 1'b0);
        cycle(8'h00, 1'b0, 1'b0);
        // Random traffic.
        r = 8'h00;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) r = 8'($urandom);
            cycle(r, ($urandom_range(0, 4) == 0), ($urandom_range(0, 199) == 0));
        end
        cycle(8'h00, 1'b0, 1'b0);
        // Drain the scoreboard within a bounded number of cycles.
        for (int i = 0; i < 5 && sb_q.size() > 0; i++) @(negedge clk);
        #1;
        n_tests++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rr_grant_ctrl.md
# rr_grant_ctrl

Round-robin arbiter that shares the 8-input one-hot Encoder between eight requesters. Each cycle it picks at most one requester, holds the grant until the owner releases, and presents both the one-hot grant vector and its 3-bit code. It sits in front of the Encoder, so the Encoder only ever sees a legal one-hot input or all-zeros.

## Interface
- N_REQ, 8: number of requesters. Fixed; must match the Encoder width.
- CODE_W, 3: width of the encoded grant index.
- HOLD_MAX, 16: maximum grant hold in cycles. Legal range 2..255. Used only when the timeout feature is compiled in.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- req  in  8  request lines, level-sensitive; bit i belongs to requester i.
- done  in  1  release pulse from the current owner, sampled only in GRANT.
- grant  out  8  registered one-hot grant, or all-zeros.
- code  out  3  index of the granted requester; 0 when `valid` is 0.
- valid  out  1  high while a grant is held.
- timeout  out  1  one-cycle pulse when a grant is forcibly revoked.

## Operation
- States: IDLE and GRANT.
- Rotating pointer `ptr` (3 bits) marks the highest-priority requester.

IDLE
- If `req` is non-zero, the winner is the first set bit found searching ptr, ptr+1, ... 7, 0, ... ptr-1.
- On the next edge: grant=1<<winner, code=winner, valid=1, `ptr`=(winner+1) mod 8 (7 wraps to 0), state→GRANT.
- If `req` is all-zeros, the block stays in IDLE and all outputs stay 0.

GRANT
- The grant is released when either `done`=1 or req[code]=0.
- Next edge after release: grant=0, code=0, valid=0, state→IDLE.
- Requests on other lines are ignored while a grant is held; there is no preemption.
- `done` together with new requests in the same cycle: the release completes first, and arbitration follows in IDLE.
- `done` in IDLE is ignored.

Reset
- Asynchronous reset at any time, including mid-grant, immediately forces grant=0, code=0, valid=0, timeout=0, ptr=0, state=IDLE, and clears the hold counter.

## Timing
- Request to grant: 1 clock edge from IDLE.
- Release to grant drop: 1 edge.
- There is at least one idle cycle (valid=0) between consecutive grants, so back-to-back requesters see a 2-cycle grant period at best.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- Macro: `RR_GRANT_TIMEOUT_EN`.
- With the macro defined:
  - An 8-bit hold counter clears on entry to GRANT and increments each cycle in GRANT.
  - If it reaches HOLD_MAX-1 with no release, the next edge revokes the grant (same result as a release) and pulses `timeout` for exactly one cycle.
  - A release in the same cycle as the limit counts as a normal release; `timeout` stays 0.
- Without the macro: no counter is built, `timeout` is tied to 0, and grants are held indefinitely.

## Structure
- Package `rr_grant_pkg` holds:
  - the `N_REQ` and `CODE_W` constants;
  - the state typedef `rr_state_t` {IDLE, GRANT};
  - the `HOLD_W`=8 constant for the counter width.
- The winner search is one combinational sub-module, `rr_pick8`. Inputs are `req` and `ptr`; outputs are a one-hot winner and an any-request flag.
- `code` comes from instantiating the team's existing Encoder on the next-state grant vector, then registering the result.

## Test plan
- Reset, then req=8'b0000_0000 for 5 cycles → grant=0, valid=0, code=0 throughout.
- req=8'b1000_0001 with ptr=0 → grant=8'h01, code=0. Pulse done; req stays 8'h81 → grant drops for 1 cycle, then grant=8'h80, code=7, and ptr wraps to 0.
- req=8'hFF held, with done pulsed each GRANT cycle → codes 0,1,2,...,7,0 in order, each separated by one valid=0 cycle.
- Grant to requester 3, then deassert req[3] with no done → valid=0 on the next edge.
- Grant to requester 5, then assert rst asynchronously mid-cycle → all outputs 0 before the next clock edge, and a later req=8'h20 grants code=5 again with ptr restarting from 0.
- With `RR_GRANT_TIMEOUT_EN` and HOLD_MAX=4: grant held with no release → revoked after 4 GRANT cycles with a single-cycle timeout=1. Without the macro, the same stimulus keeps valid=1 and timeout=0.
